// File: rtl/u8_ccc_lock_rstgen.sv
// Reset generator for fabric logic clocked by the CCC global clock: holds RST_N low until the
// PLL LOCK has been stable long enough, and tracks lock losses seen while running.
module u8_ccc_lock_rstgen #(
    parameter int unsigned LOCK_STABLE_CYCLES = 4096,
    parameter int unsigned RST_MIN_CYCLES     = 16
) (
    input  logic       CLK,
    input  logic       ARST_N,
    input  logic       LOCK,
    input  logic       CLR_STKY,
    output logic       RST_N,
    output logic       READY,
    output logic       LOCK_LOST_STKY,
    output logic [7:0] LOCK_LOST_CNT
);

    typedef enum logic [1:0] {
        StWaitLock,
        StStable,
        StRun,
        StLost
    } state_e;

    // One shared counter: stability count in StStable, hold count in StLost.
    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(RST_MIN_CYCLES - 1);

    logic [1:0]  sync_q;
    logic        lock_s;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lost_evt;
    logic        rst_n_q;
    logic        ready_q;
    logic        stky_q, stky_d;
    logic [7:0]  lost_cnt_q, lost_cnt_d;

    // LOCK is asynchronous to CLK; nothing else may look at it.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], LOCK};
        end
    end

    assign lock_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lost_evt = 1'b0;
        case (state_q)
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d  = StLost;
                    cnt_d    = '0;
                    lost_evt = 1'b1;
                end
            end
            StLost: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase
    end

    // A lock loss on the same edge as a clear request keeps the flag set.
    always_comb begin
        stky_d     = stky_q;
        lost_cnt_d = lost_cnt_q;
        if (lost_evt) begin
            stky_d = 1'b1;
            if (lost_cnt_q != 8'hFF) begin
                lost_cnt_d = lost_cnt_q + 8'd1;
            end
        end else if (CLR_STKY) begin
            stky_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= StWaitLock;
            cnt_q      <= '0;
            rst_n_q    <= 1'b0;
            ready_q    <= 1'b0;
            stky_q     <= 1'b0;
            lost_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_n_q    <= (state_d == StRun);
            ready_q    <= (state_d == StRun);
            stky_q     <= stky_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign RST_N          = rst_n_q;
    assign READY          = ready_q;
    assign LOCK_LOST_STKY = stky_q;
    assign LOCK_LOST_CNT  = lost_cnt_q;

endmodule

// File: doc/u8_ccc_lock_rstgen.md
U8_CCC_LOCK_RSTGEN -- requirements
Module: u8_ccc_lock_rstgen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be CLK and the reset port SHALL be ARST_N.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 4096, SHALL set the number of cycles LOCK must stay high before reset release; legal values are 2 to 65535.
REQ-003 Parameter RST_MIN_CYCLES, default 16, SHALL set the minimum number of cycles RST_N stays low after a lock loss; legal values are 1 to 255.
REQ-004 CLK SHALL be an input, 1 bit: the CCC global clock output GL0.
REQ-005 ARST_N SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 LOCK SHALL be an input, 1 bit: the CCC PLL LOCK, asynchronous to CLK.
REQ-007 CLR_STKY SHALL be an input, 1 bit: synchronous clear of LOCK_LOST_STKY.
REQ-008 RST_N SHALL be an output, 1 bit: registered, active-low reset for fabric logic in the CLK domain.
REQ-009 READY SHALL be an output, 1 bit: high exactly while state is RUN.
REQ-010 LOCK_LOST_STKY SHALL be an output, 1 bit: sticky flag set on any lock loss in RUN.
REQ-011 LOCK_LOST_CNT SHALL be an output, 8 bits: saturating count of lock losses in RUN.

Function
REQ-012 LOCK SHALL pass through a 2-flop synchronizer (lock_s) before use; no other logic SHALL sample LOCK directly.
REQ-013 The FSM SHALL have the states WAIT_LOCK, STABLE, RUN and LOST.
REQ-014 WAIT_LOCK: RST_N=0; when lock_s=1 the FSM SHALL go to STABLE with the stability counter cleared to 0.
REQ-015 STABLE: the counter SHALL increment each cycle lock_s=1; lock_s=0 SHALL return to WAIT_LOCK, clear the counter, and leave LOCK_LOST_CNT and LOCK_LOST_STKY unchanged.
REQ-016 STABLE: when the counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1, the FSM SHALL enter RUN, with RST_N=1 and READY=1 from that edge.
REQ-017 Latency: counting the first edge that samples LOCK=1 as edge 1, RST_N SHALL rise on edge LOCK_STABLE_CYCLES+3 if LOCK stays high throughout.
REQ-018 RUN: lock_s=0 SHALL enter LOST on the next edge, with RST_N=0 and READY=0 on that edge (edge 3 counting the first edge that samples LOCK=0).
REQ-019 On RUN->LOST: LOCK_LOST_CNT SHALL increment, saturating at 255 (no wrap), and LOCK_LOST_STKY SHALL be set.
REQ-020 LOST: the FSM SHALL hold RST_N=0 for exactly RST_MIN_CYCLES cycles, then go to WAIT_LOCK regardless of lock_s.
REQ-021 LOST->WAIT_LOCK with lock_s already high SHALL enter STABLE on the following edge; the full LOCK_STABLE_CYCLES count SHALL be required again.
REQ-022 CLR_STKY=1 SHALL clear LOCK_LOST_STKY on the next edge; if it coincides with a RUN->LOST transition, the set SHALL win.
REQ-023 LOCK_LOST_CNT SHALL be cleared only by ARST_N.
REQ-024 All outputs SHALL be driven directly from flops.

Reset
REQ-025 ARST_N=0 SHALL immediately force: state WAIT_LOCK, synchronizer flops 0, both counters 0, RST_N=0, READY=0, LOCK_LOST_STKY=0, LOCK_LOST_CNT=0.
REQ-026 ARST_N asserted mid-STABLE or mid-RUN SHALL abort the operation with no count retained; after ARST_N deasserts, release SHALL require the full REQ-017 latency.
REQ-027 ARST_N deassertion SHALL be synchronized externally; the block SHALL NOT depend on LOCK during reset.

Verification (bench uses LOCK_STABLE_CYCLES=8, RST_MIN_CYCLES=4)
REQ-028 Clean lock: release ARST_N, then raise LOCK and hold it high -> RST_N and READY rise on edge 11; LOCK_LOST_CNT=0, STKY=0.
REQ-029 Glitch in STABLE: LOCK high for 5 cycles, low for 3, then high -> no release before 11 edges after the second rise; CNT=0, STKY=0.
REQ-030 Loss in RUN: from RUN, drop LOCK for 1 cycle -> RST_N=0 on edge 3; it stays low at least 4 cycles, then re-releases after 8 more stable cycles; CNT=1, STKY=1.
REQ-031 Saturation: 260 loss/relock cycles -> LOCK_LOST_CNT=255 and stays there.
REQ-032 CLR_STKY asserted on the same edge as RUN->LOST -> STKY=1; CLR_STKY one cycle later -> STKY=0 and CNT unchanged.
REQ-033 ARST_N pulsed low mid-RUN -> RST_N=0 and CNT=0 asynchronously; with LOCK held high, RST_N rises 11 edges after ARST_N deasserts.
